aquarium_sensor_scanner: RTL and testbench

//  Parametrised tank-sensor bank: NUM_CH capture registers (cleanliness, temperature, food, saltiness, ...).

---
 rtl/aquarium_sensor_scanner.sv | 175 +++++++++++++++++
 tb/tb_aquarium_sensor_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aquarium_sensor_scanner.sv
// Tank sensor bank: per-channel capture registers with threshold alarms, plus a scan
// sequencer that drives one registered display channel (auto round-robin or manual).
module aquarium_sensor_scanner #(
  parameter int                NUM_CH  = 4,
  parameter int                DATA_W  = 8,
  parameter int                DWELL   = 4,
  parameter logic [DATA_W-1:0] ERR_VAL = '0
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] d_in,
  input  logic [NUM_CH-1:0]        d_load,
  input  logic                     scan_en,
  input  logic                     mode,
  input  logic [3:0]               sel_ch,
  input  logic                     thr_wr,
  input  logic [3:0]               thr_ch,
  input  logic [DATA_W-1:0]        thr_lo,
  input  logic [DATA_W-1:0]        thr_hi,
  input  logic                     alarm_clr,
  output logic [DATA_W-1:0]        out,
  output logic [3:0]               out_ch,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     err
);

  localparam int             CH_W       = $clog2(NUM_CH);
  localparam int             DW_W       = $clog2(DWELL) + 1;
  localparam logic [4:0]     NUM_CH_L   = 5'(NUM_CH);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ERROR} state_t;

  logic [DATA_W-1:0] sample_reg [NUM_CH];
  logic [DATA_W-1:0] thr_lo_reg [NUM_CH];
  logic [DATA_W-1:0] thr_hi_reg [NUM_CH];
  logic [DATA_W-1:0] d_slice    [NUM_CH];
  logic [NUM_CH-1:0] thr_hit;
  logic [NUM_CH-1:0] alarm_set;
  logic [NUM_CH-1:0] alarm_reg, alarm_next;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [DW_W-1:0]   dwell_reg, dwell_next;
  logic [DATA_W-1:0] out_reg, out_next;
  logic [3:0]        out_ch_reg, out_ch_next;
  logic              out_valid_reg, out_valid_next;
  logic              err_reg, err_next;
  logic              sel_ok;

  // Alarm compare sees the thresholds held before the edge, so a same-edge
  // threshold write never affects the sample being captured.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign d_slice[gi]   = d_in[gi*DATA_W +: DATA_W];
      assign thr_hit[gi]   = thr_wr && (thr_ch == 4'(gi));
      assign alarm_set[gi] = d_load[gi] &&
                             ((d_slice[gi] < thr_lo_reg[gi]) || (d_slice[gi] > thr_hi_reg[gi]));
    end
  endgenerate

  assign alarm_next = (alarm_clr ? '0 : alarm_reg) | alarm_set;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sample_reg[i] <= '0;
        thr_lo_reg[i] <= '0;
        thr_hi_reg[i] <= '1;
      end
      alarm_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (d_load[i]) sample_reg[i] <= d_slice[i];
        if (thr_hit[i]) begin
          thr_lo_reg[i] <= thr_lo;
          thr_hi_reg[i] <= thr_hi;
        end
      end
      alarm_reg <= alarm_next;
    end
  end

  assign sel_ok = {1'b0, sel_ch} < NUM_CH_L;

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    dwell_next     = dwell_reg;
    out_next       = out_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    err_next       = err_reg;
    case (state_reg)
      S_IDLE: begin
        out_valid_next = 1'b0;
        if (scan_en) begin
          state_next = S_SCAN;
          ch_next    = '0;
          dwell_next = '0;
        end
      end
      S_SCAN: begin
        if (!scan_en) begin
          state_next     = S_IDLE;
          out_valid_next = 1'b0;
        end else if (mode) begin
          // Holding the auto position at 0 makes a return to auto restart cleanly.
          ch_next    = '0;
          dwell_next = '0;
          if (!sel_ok) begin
            state_next     = S_ERROR;
            out_next       = ERR_VAL;
            out_valid_next = 1'b0;
            err_next       = 1'b1;
          end else begin
            out_next       = sample_reg[sel_ch[CH_W-1:0]];
            out_ch_next    = sel_ch;
            out_valid_next = 1'b1;
          end
        end else begin
          out_next       = sample_reg[ch_reg];
          out_ch_next    = 4'(ch_reg);
          out_valid_next = 1'b1;
          if (dwell_reg == DWELL_LAST) begin
            dwell_next = '0;
            ch_next    = (ch_reg == CH_LAST) ? '0 : ch_reg + CH_W'(1);
          end else begin
            dwell_next = dwell_reg + DW_W'(1);
          end
        end
      end
      S_ERROR: begin
        out_next       = ERR_VAL;
        out_valid_next = 1'b0;
        err_next       = 1'b1;
        if (alarm_clr && (!mode || sel_ok)) begin
          state_next = S_IDLE;
          err_next   = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      ch_reg        <= '0;
      dwell_reg     <= '0;
      out_reg       <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      dwell_reg     <= dwell_next;
      out_reg       <= out_next;
      out_ch_reg    <= out_ch_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign out       = out_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign alarm     = alarm_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_aquarium_sensor_scanner.sv
// Bench for aquarium_sensor_scanner: directed vectors, literal checks and a
// per-cycle comparison against a behavioural model of the scanner.
module tb_aquarium_sensor_scanner;

  localparam int NC = 4;
  localparam int DW = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] d_in;
  logic [3:0]  d_load;
  logic        scan_en, mode, thr_wr, alarm_clr;
  logic [3:0]  sel_ch, thr_ch;
  logic [7:0]  thr_lo, thr_hi;
  logic [7:0]  out;
  logic [3:0]  out_ch;
  logic        out_valid, err;
  logic [3:0]  alarm;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  aquarium_sensor_scanner #(.NUM_CH(NC), .DATA_W(8), .DWELL(DW), .ERR_VAL(8'h00)) dut (
    .CLK(CLK), .reset(reset), .d_in(d_in), .d_load(d_load), .scan_en(scan_en),
    .mode(mode), .sel_ch(sel_ch), .thr_wr(thr_wr), .thr_ch(thr_ch), .thr_lo(thr_lo),
    .thr_hi(thr_hi), .alarm_clr(alarm_clr), .out(out), .out_ch(out_ch),
    .out_valid(out_valid), .alarm(alarm), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: auto position is derived from elapsed auto cycles.
  logic [7:0] m_s [NC];
  logic [7:0] m_lo [NC];
  logic [7:0] m_hi [NC];
  logic [3:0] m_alarm;
  int         ph;       // 0 idle, 1 scanning, 2 error
  int         auto_t;
  logic [7:0] e_out;
  logic [3:0] e_ch;
  logic       e_valid, e_err;

  always @(posedge CLK) begin
    logic [3:0] na;
    logic [7:0] v;
    int c;
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        m_s[i] = 8'h00; m_lo[i] = 8'h00; m_hi[i] = 8'hFF;
      end
      m_alarm = 4'h0; ph = 0; auto_t = 0;
      e_out = 8'h00; e_ch = 4'h0; e_valid = 1'b0; e_err = 1'b0;
    end else begin
      na = alarm_clr ? 4'h0 : m_alarm;
      for (int i = 0; i < NC; i++) begin
        v = d_in[i*8 +: 8];
        if (d_load[i] && (v < m_lo[i] || v > m_hi[i])) na[i] = 1'b1;
      end
      if (ph == 0) begin
        e_valid = 1'b0;
        if (scan_en) begin ph = 1; auto_t = 0; end
      end else if (ph == 1) begin
        if (!scan_en) begin
          ph = 0; e_valid = 1'b0;
        end else if (mode) begin
          auto_t = 0;
          if (int'(sel_ch) >= NC) begin
            ph = 2; e_out = 8'h00; e_valid = 1'b0; e_err = 1'b1;
          end else begin
            e_out = m_s[int'(sel_ch)]; e_ch = sel_ch; e_valid = 1'b1;
          end
        end else begin
          c = (auto_t / DW) % NC;
          e_out = m_s[c]; e_ch = 4'(c); e_valid = 1'b1;
          auto_t++;
        end
      end else begin
        if (alarm_clr && (!mode || int'(sel_ch) < NC)) begin ph = 0; e_err = 1'b0; end
      end
      for (int i = 0; i < NC; i++) begin
        if (d_load[i]) m_s[i] = d_in[i*8 +: 8];
        if (thr_wr && int'(thr_ch) == i) begin m_lo[i] = thr_lo; m_hi[i] = thr_hi; end
      end
      m_alarm = na;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("cyc_out", 32'(out), 32'(e_out));
      chk("cyc_out_ch", 32'(out_ch), 32'(e_ch));
      chk("cyc_valid", 32'(out_valid), 32'(e_valid));
      chk("cyc_alarm", 32'(alarm), 32'(m_alarm));
      chk("cyc_err", 32'(err), 32'(e_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [7:0] vals [4];

  initial begin
    vals[0] = 8'h0E; vals[1] = 8'h1C; vals[2] = 8'h38; vals[3] = 8'h70;
    reset = 1'b0; d_in = '0; d_load = '0; scan_en = 0; mode = 0; sel_ch = 0;
    thr_wr = 0; thr_ch = 0; thr_lo = 0; thr_hi = 0; alarm_clr = 0;
    cyc(2);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_alarm", 32'(alarm), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    started = 1'b1;
    reset = 1'b1;

    // Auto round-robin
    d_in = {8'h70, 8'h38, 8'h1C, 8'h0E}; d_load = 4'hF;
    cyc(1);
    d_load = 4'h0; scan_en = 1'b1; mode = 1'b0;
    cyc(1);
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("auto_ch", 32'(out_ch), 32'((k / 4) % 4));
      chk("auto_out", 32'(out), 32'(vals[(k / 4) % 4]));
    end

    // Load while displayed: restart scan on ch0
    scan_en = 1'b0; cyc(1);
    scan_en = 1'b1; cyc(1);
    d_in[7:0] = 8'h55; d_load = 4'h1;
    cyc(1);
    chk("load_old", 32'(out), 32'h0E);
    d_load = 4'h0;
    cyc(1);
    chk("load_new", 32'(out), 32'h55);

    // Manual select, bad channel, recovery
    mode = 1'b1; sel_ch = 4'd2;
    cyc(1);
    chk("man_out", 32'(out), 32'h38);
    chk("man_ch", 32'(out_ch), 32'd2);
    sel_ch = 4'd5;
    cyc(1);
    chk("man_err", 32'(err), 32'h1);
    chk("man_errout", 32'(out), 32'h00);
    sel_ch = 4'd1; alarm_clr = 1'b1; scan_en = 1'b0;
    cyc(1);
    chk("man_clr", 32'(err), 32'h0);
    alarm_clr = 1'b0;
    cyc(1);

    // Thresholds and sticky alarms
    thr_wr = 1'b1; thr_ch = 4'd1; thr_lo = 8'h10; thr_hi = 8'h20;
    cyc(1);
    thr_wr = 1'b0; d_in[15:8] = 8'h25; d_load = 4'h2;
    cyc(1);
    chk("alm_set", 32'(alarm[1]), 32'h1);
    d_load = 4'h0;
    cyc(2);
    chk("alm_sticky", 32'(alarm[1]), 32'h1);
    d_in[15:8] = 8'h18; d_load = 4'h2;
    cyc(1);
    chk("alm_inrange", 32'(alarm[1]), 32'h1);
    d_in[15:8] = 8'h30; alarm_clr = 1'b1;
    cyc(1);
    chk("alm_setwins", 32'(alarm[1]), 32'h1);
    d_load = 4'h0;
    cyc(1);
    chk("alm_clr", 32'(alarm), 32'h0);
    alarm_clr = 1'b0;
    thr_wr = 1'b1; thr_lo = 8'h00; thr_hi = 8'hFF; d_in[15:8] = 8'h30; d_load = 4'h2;
    cyc(1);
    chk("alm_oldthr", 32'(alarm[1]), 32'h1);
    d_load = 4'h0; thr_ch = 4'd7; thr_lo = 8'h50;
    cyc(1);
    thr_wr = 1'b0; alarm_clr = 1'b1; d_in[31:24] = 8'h40; d_load = 4'h8;
    cyc(1);
    chk("thr_ignored", 32'(alarm), 32'h0);
    alarm_clr = 1'b0; d_load = 4'h0;

    // Reset during ch2 dwell
    thr_wr = 1'b1; thr_ch = 4'd1; thr_lo = 8'h10; thr_hi = 8'h20;
    cyc(1);
    thr_wr = 1'b0; d_in[15:8] = 8'h05; d_load = 4'h2;
    cyc(1);
    d_load = 4'h0; mode = 1'b0; scan_en = 1'b1;
    cyc(1);
    cyc(9);
    chk("mid_ch2", 32'(out_ch), 32'd2);
    reset = 1'b0;
    cyc(1);
    chk("mid_out", 32'(out), 32'h0);
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_alarm", 32'(alarm), 32'h0);
    reset = 1'b1; mode = 1'b1; sel_ch = 4'd3;
    cyc(2);
    chk("mid_reg3", 32'(out), 32'h0);
    chk("mid_valid2", 32'(out_valid), 32'h1);
    d_in[15:8] = 8'h25; d_load = 4'h2;
    cyc(1);
    chk("mid_thrdef", 32'(alarm), 32'h0);
    d_load = 4'h0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
